// File: rtl/bus_slave_pkg.sv
// Shared types and widths for the bus_slave_mem write-only memory slave.
package bus_slave_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/slave_mem_array.sv
// DEPTH x DW word storage: one synchronous write port, one asynchronous read port.
module slave_mem_array #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned DW    = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_slave_mem.sv
// Write-only bus memory slave with programmable wait states and a one-cycle ready pulse.
// Optional range check enabled by defining BUS_SLAVE_RANGE_CHK_EN.
module bus_slave_mem
  import bus_slave_pkg::*;
#(
  parameter  int unsigned       DEPTH       = 64,
  parameter  logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter  int unsigned       WAIT_STATES = 1,
  localparam int unsigned       AW          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_valid,
  output logic              slave_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       wr_count,
  output logic              bus_err
);

  localparam logic [WCNT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? '0 : WCNT_W'(WAIT_STATES - 1);

  state_t              state;
  state_t              next_state;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   wcnt_d;
  logic                cap_en_c;
  bus_req_t            cap;
  logic [ADDR_W-1:0]   offset_c;
  logic [AW-1:0]       widx_c;
  logic                oor_c;
  logic                we_c;
  logic                unused_offset_lo;

  // Decode always works from the captured request, never the live bus.
  assign offset_c         = cap.addr - BASE_ADDR;
  assign widx_c           = offset_c[AW+1:2];
  assign unused_offset_lo = ^offset_c[1:0];

`ifdef BUS_SLAVE_RANGE_CHK_EN
  assign oor_c = |offset_c[ADDR_W-1:AW+2];
`else
  logic unused_offset_hi;
  assign unused_offset_hi = |offset_c[ADDR_W-1:AW+2];
  assign oor_c            = 1'b0;
`endif

  // Commit on the edge leaving ACK; a coincident reset cancels it.
  assign we_c = (state == ACK) && !rst && !oor_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= next_state;
      wcnt  <= wcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    wcnt_d     = wcnt;
    cap_en_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus_valid) begin
          cap_en_c = 1'b1;
          if (WAIT_STATES == 0) begin
            next_state = ACK;
          end else begin
            wcnt_d     = WS_LOAD;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wcnt == '0) next_state = ACK;
        else            wcnt_d     = wcnt - WCNT_W'(1);
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture, ready pulse and write counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap         <= '0;
      slave_ready <= 1'b0;
      wr_count    <= '0;
    end else begin
      if (cap_en_c) begin
        cap.addr  <= bus_addr;
        cap.wdata <= bus_wdata;
      end
      slave_ready <= (next_state == ACK);
      if (we_c) wr_count <= wr_count + 16'd1;
    end
  end

`ifdef BUS_SLAVE_RANGE_CHK_EN
  // Sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        bus_err <= 1'b0;
    else if (state == ACK && oor_c) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

  slave_mem_array #(
    .DEPTH (DEPTH),
    .DW    (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (we_c),
    .waddr (widx_c),
    .wdata (cap.wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench for bus_slave_mem: dut0 with 1 wait state, dut1 with 3 wait states.
`timescale 1ns/1ps
module tb_bus_slave_mem;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   b_addr0, b_wdata0, b_addr1, b_wdata1;
  logic          b_valid0, b_valid1;
  logic          ready0, ready1;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [31:0]   rd_data0, rd_data1;
  logic [15:0]   wr_count0, wr_count1;
  logic          bus_err0, bus_err1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int q0[$];
  int q1[$];

  bus_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst), .bus_addr(b_addr0), .bus_wdata(b_wdata0),
    .bus_valid(b_valid0), .slave_ready(ready0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .wr_count(wr_count0), .bus_err(bus_err0)
  );

  bus_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .bus_addr(b_addr1), .bus_wdata(b_wdata1),
    .bus_valid(b_valid1), .slave_ready(ready1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .wr_count(wr_count1), .bus_err(bus_err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected_ready(input string name);
    checks++;
    errors++;
    $display("FAIL %s: ready pulse at cycle %0d with no transaction pending", name, cyc);
  endtask

  // Monitor: every ready pulse must match the cycle predicted at issue time.
  always @(negedge clk) begin
    if (!rst && ready0) begin
      if (q0.size() == 0) unexpected_ready("dut0 ready");
      else check("dut0 ready cycle", 32'(cyc), 32'(q0.pop_front()));
    end
    if (!rst && ready1) begin
      if (q1.size() == 0) unexpected_ready("dut1 ready");
      else check("dut1 ready cycle", 32'(cyc), 32'(q1.pop_front()));
    end
  end

  task automatic set_bus(input int u, input logic [31:0] a, input logic [31:0] d, input logic v);
    if (u == 0) begin b_addr0 = a; b_wdata0 = d; b_valid0 = v; end
    else        begin b_addr1 = a; b_wdata1 = d; b_valid1 = v; end
  endtask

  function automatic logic get_ready(input int u);
    return (u == 0) ? ready0 : ready1;
  endfunction

  // mode 0: normal; 1: corrupt addr/data during WAIT; 2: drop valid during WAIT
  task automatic bus_write(input int u, input logic [31:0] a, input logic [31:0] d,
                           input int ws, input int mode);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    set_bus(u, a, d, 1'b1);
    if (u == 0) q0.push_back(cyc + ws + 1);
    else        q1.push_back(cyc + ws + 1);
    if (mode != 0) begin
      @(posedge clk); #1;
      if (mode == 1) set_bus(u, 32'h10, 32'h0, 1'b1);
      else           set_bus(u, a, d, 1'b0);
    end
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = get_ready(u);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL bus_write timeout: dut%0d no ready within 40 cycles, required 1", u);
      if (u == 0) q0.delete(); else q1.delete();
    end
    @(posedge clk); #1;
    set_bus(u, a, d, 1'b0);
  endtask

  task automatic check_word(input int u, input int idx, input logic [31:0] exp, input string name);
    if (u == 0) rd_addr0 = AW'(idx); else rd_addr1 = AW'(idx);
    #1;
    check(name, (u == 0) ? rd_data0 : rd_data1, exp);
  endtask

  task automatic check_cnt(input int u, input int exp, input string name);
    check(name, {16'h0, (u == 0) ? wr_count0 : wr_count1}, 32'(exp));
  endtask

  initial begin
    logic [31:0] w0_exp;
    int          cnt_exp;
    int          rc;

    rst = 1'b1;
    set_bus(0, 32'h40, 32'hFFFF0000, 1'b1);
    set_bus(1, 32'h40, 32'hFFFF0000, 1'b1);
    rd_addr0 = '0;
    rd_addr1 = '0;

    // Reset held with valid high
    repeat (3) begin
      @(negedge clk);
      check("reset ready",    {31'b0, ready0},   32'h0);
      check("reset wr_count", {16'h0, wr_count0}, 32'h0);
      check("reset bus_err",  {31'b0, bus_err0}, 32'h0);
      check("reset ready1",   {31'b0, ready1},   32'h0);
    end
    @(posedge clk); #1;
    set_bus(0, 32'h0, 32'h0, 1'b0);
    set_bus(1, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_cnt(0, 0, "wr_count after reset");

    // Single write, then minimum-spaced sequence
    bus_write(0, 32'h8, 32'hDEADBEEF, 1, 0);
    check_word(0, 2, 32'hDEADBEEF, "word2 single write");
    check_cnt(0, 1, "wr_count single");

    bus_write(0, 32'h0,  32'h11111111, 1, 0);
    bus_write(0, 32'h4,  32'h22222222, 1, 0);
    bus_write(0, 32'hFC, 32'h33333333, 1, 0);
    check_word(0, 0,  32'h11111111, "word0 seq");
    check_word(0, 1,  32'h22222222, "word1 seq");
    check_word(0, 63, 32'h33333333, "word63 seq");
    check_word(0, 2,  32'hDEADBEEF, "word2 untouched");
    check_cnt(0, 4, "wr_count seq");

    // Low address bits ignored
    bus_write(0, 32'hB, 32'hCAFEF00D, 1, 0);
    check_word(0, 2, 32'hCAFEF00D, "word2 unaligned addr");
    check_cnt(0, 5, "wr_count unaligned");

    // Out-of-range access at 0x100
    bus_write(0, 32'h100, 32'h5A5A5A5A, 1, 0);
`ifdef BUS_SLAVE_RANGE_CHK_EN
    w0_exp  = 32'h11111111;
    cnt_exp = 5;
    check("oor bus_err", {31'b0, bus_err0}, 32'h1);
`else
    w0_exp  = 32'h5A5A5A5A;
    cnt_exp = 6;
    check("wrap bus_err", {31'b0, bus_err0}, 32'h0);
`endif
    check_word(0, 0, w0_exp, "word0 after 0x100");
    check_cnt(0, cnt_exp, "wr_count after 0x100");
    bus_write(0, 32'h4, 32'h44444444, 1, 0);
    check_word(0, 1, 32'h44444444, "word1 after oor");
    check_cnt(0, cnt_exp + 1, "wr_count after oor");
`ifdef BUS_SLAVE_RANGE_CHK_EN
    check("bus_err sticky", {31'b0, bus_err0}, 32'h1);
`else
    check("bus_err tied", {31'b0, bus_err0}, 32'h0);
`endif

    // Three wait states: capture rule and valid dropped during WAIT
    bus_write(1, 32'h10, 32'h44440000, 3, 0);
    check_word(1, 4, 32'h44440000, "dut1 word4");
    bus_write(1, 32'hC, 32'h12345678, 3, 1);
    check_word(1, 3, 32'h12345678, "dut1 captured write");
    check_word(1, 4, 32'h44440000, "dut1 word4 unchanged");
    bus_write(1, 32'h14, 32'hBEEF0005, 3, 2);
    check_word(1, 5, 32'hBEEF0005, "dut1 valid dropped");
    check_cnt(1, 3, "dut1 wr_count");

    // Reset during WAIT drops the pending write
    @(posedge clk); #1;
    set_bus(0, 32'h0, 32'hA5A5A5A5, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_bus(0, 32'h0, 32'hA5A5A5A5, 1'b0);
    #2;
    rst = 1'b0;
    rc = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready0) rc++;
    end
    check("rst-in-wait ready pulses", 32'(rc), 32'h0);
    check_word(0, 0, w0_exp, "word0 after aborted write");
    check_cnt(0, 0, "wr_count after rst-in-wait");
    check("bus_err after rst", {31'b0, bus_err0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_slave_mem.md
Name: bus_slave_mem

Overview:
- Write-only memory slave that sits directly downstream of the CPU core's external bus.
- Consumes the core's address bus, write-data bus and valid strobe, inserts a programmable number of wait states, and returns a one-cycle ready pulse.
- Commits each accepted word into a local word-addressed RAM.
- Provides an asynchronous read-back port and a write counter for debug and verification.

Parameters:
- DEPTH, 64: number of 32-bit words; must be a power of 2, minimum 2.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; must be 4-byte aligned.
- WAIT_STATES, 1: wait cycles inserted before ready; legal range 0..15.
- AW, log2(DEPTH): derived word-index width; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_addr  in  32  byte address from the core's address register.
- bus_wdata  in  32  write data from the core's data bus.
- bus_valid  in  1  master request; held high until slave_ready is seen.
- slave_ready  out  1  one-cycle completion pulse.
- rd_addr  in  AW  debug read word index.
- rd_data  out  32  combinational read of mem[rd_addr].
- wr_count  out  16  number of committed writes.
- bus_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; slave_ready=0, wr_count=0, bus_err=0; capture registers are cleared.
  - RAM contents are not reset. Unwritten words are undefined and must not be checked.
- State machine, IDLE / WAIT / ACK:
  - IDLE: if bus_valid=1 at the edge, capture bus_addr and bus_wdata. Go to ACK if WAIT_STATES==0; otherwise load wcnt=WAIT_STATES-1 and go to WAIT. If bus_valid=0, stay in IDLE.
  - WAIT: if wcnt==0 go to ACK, else decrement wcnt. bus_addr and bus_wdata are ignored here; the captured values win.
  - ACK: slave_ready=1 for exactly this cycle. The write commits on the edge that leaves ACK. Next state is always IDLE.
- Latency and throughput:
  - bus_valid is first sampled high at the end of cycle 0.
  - slave_ready is high in cycle WAIT_STATES+1.
  - rd_data reflects the new word from cycle WAIT_STATES+2.
  - There is at least one IDLE cycle between transactions. The master drops bus_valid in the cycle after it sees ready; if bus_valid is still high in that IDLE cycle, a new transaction starts.
- Address decode:
  - offset = bus_addr - BASE_ADDR (32-bit unsigned).
  - Word index = offset[AW+1:2]; offset[1:0] is ignored, so there are no byte lanes.
- wr_count increments by 1 on each committed write and wraps from 0xFFFF to 0x0000.
- Reset mid-operation (during WAIT or ACK): the pending write is dropped, no ready pulse is produced, and wr_count stays 0.
- bus_valid deasserted during WAIT: the transaction still completes. The protocol forbids this, but the slave must not hang.

Optional Feature:
- Macro: BUS_SLAVE_RANGE_CHK_EN.
- Defined:
  - An access is out of range when offset >= 4*DEPTH, with offset computed as above (unsigned compare after subtraction).
  - Out-of-range accesses still complete the handshake (ready pulse).
  - They perform no RAM write and no wr_count increment.
  - They set bus_err, which stays 1 until rst.
- Undefined:
  - No check; the index silently wraps modulo DEPTH.
  - bus_err is tied to 0.

Decomposition:
- Shared package (bus_slave_pkg):
  - bus data width constant (32) and address width constant (32);
  - FSM state typedef with encodings IDLE=2'd0, WAIT=2'd1, ACK=2'd2;
  - wait-counter width constant (4).
- One sub-module: slave_mem_array, holding DEPTH x 32 storage with one synchronous write port (we, waddr, wdata) and one asynchronous read port.

Test Plan:
- Reset: assert rst for 3 cycles with bus_valid=1 -> slave_ready=0, wr_count=0, bus_err=0 throughout; no write occurs.
- Single write, WAIT_STATES=1: bus_addr=0x8, bus_wdata=0xDEADBEEF, bus_valid high from cycle 0 -> slave_ready high only in cycle 2; with rd_addr=2, rd_data=0xDEADBEEF from cycle 3; wr_count=1.
- Sequence, DEPTH=64: writes 0x11111111 to 0x0, 0x22222222 to 0x4, 0x33333333 to 0xFC, each with minimum spacing -> words 0, 1, 63 hold those values; wr_count=3; each ready is exactly 1 cycle wide.
- Capture rule, WAIT_STATES=3: change bus_addr to 0x10 and bus_wdata to 0x0 during WAIT -> the originally captured address and data are written; word 4 is unchanged.
- Reset in WAIT: pulse rst during cycle 1 of a write of 0xA5A5A5A5 to 0x0 -> no ready pulse; word 0 keeps its prior value; wr_count=0.
- Out of range, bus_addr=0x100, DEPTH=64: with the macro -> ready pulses, word 0 unchanged, bus_err=1 and still 1 after a later valid write. Without the macro -> word 0 is written and bus_err=0.
